shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_a, req_b  input  1 each  level request from requester A / B.
REQ-005 data_a, data_b  input  8 each  operand for A / B.
REQ-006 shamt_a, shamt_b  input  3 each  rotate amount 0..7 for A / B.
REQ-007 dir_a, dir_b  input  1 each  direction: 0 = rotate left, 1 = rotate right.
REQ-008 gnt_a, gnt_b  output  1 each  registered one-cycle pulse: operands of A / B captured.
REQ-009 done_a, done_b  output  1 each  registered one-cycle pulse: result for A / B valid.
REQ-010 result  output  8  registered rotate result, held until next done.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 op_count  output  8  completed-operation counter, saturating at 0xFF.

Function
REQ-013 The block SHALL share one combinational 8-bit bidirectional rotator between A and B.
- Left rotate by k: result = {x[7-k:0], x[7:8-k]}.
- Right rotate by k: result = {x[k-1:0], x[7:k]}.
- shamt = 0 gives result = operand; shamt = 4 gives the same result in either direction.
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP.
- IDLE -> EXEC when any req is high at a clock edge.
- EXEC -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-015 At the IDLE->EXEC edge, the block SHALL register the winner's data/shamt/dir and an owner bit.
- The matching gnt pulses high for exactly the EXEC cycle.
REQ-016 At the EXEC->RESP edge, result SHALL load the rotator output of the registered operands.
- The owner's done pulses high for exactly the RESP cycle.
- op_count increments by 1 at this edge, unless it is already 0xFF.
REQ-017 Latency and throughput:
- Request sampled at edge N -> gnt in cycle N+1, done in cycle N+2.
- Next grant can be sampled at edge N+3, giving one operation per 3 cycles at most.
REQ-018 Arbitration SHALL be round-robin on a last-owner bit.
- Single request: that requester wins.
- Both requesting: the requester not equal to last-owner wins.
- last-owner updates at every grant.
REQ-019 Requests in EXEC or RESP SHALL be ignored (not queued); a req still high in IDLE is a new request.
- Requesters drop req after gnt.
REQ-020 gnt_a/gnt_b SHALL never be high together, and done_a/done_b SHALL never be high together.
REQ-021 Operand inputs changing after capture SHALL NOT affect the in-flight result.
REQ-022 result SHALL hold its value outside RESP edges; it is not cleared on the next grant.

Reset
REQ-023 While rst_n = 0 the block SHALL force the following values, independent of clk:
- state = IDLE, last-owner = B (so A wins the first tie).
- result = 0x00, op_count = 0x00.
- gnt_a = gnt_b = done_a = done_b = busy = 0.
REQ-024 Reset asserted in EXEC or RESP SHALL abort the operation: no done is issued and op_count is not incremented.
REQ-025 After rst_n deasserts, the first request SHALL be sampled at the first rising edge with rst_n = 1.

Verification
REQ-026 Single-request scenario: A with data 0x81, shamt 1, dir 0 -> gnt_a in cycle N+1, done_a in cycle N+2, result 0x03, op_count 1.
REQ-027 Right-rotate scenario: B with data 0x01, shamt 3, dir 1 -> done_b with result 0x20; the same with shamt 0 -> result 0x01.
REQ-028 Symmetry scenario: data 0xA5, shamt 4, dir 0 and then dir 1 -> result 0x5A both times.
REQ-029 Fairness scenario: req_a and req_b held high from reset for 6 operations -> grant order A,B,A,B,A,B, with no overlap of gnt or done.
REQ-030 Abort scenario: rst_n pulsed low during EXEC -> no done pulse, result 0x00, op_count 0, busy 0; after release a new A request completes normally.
REQ-031 Saturation scenario: 256 back-to-back operations -> op_count stops at 0xFF and stays at 0xFF on the 257th operation.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter sharing one 8-bit bidirectional rotator.
// Each operation runs IDLE -> EXEC -> RESP, so at most one completes every three cycles.
module shift_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [2:0] shamt_a,
  input  logic [2:0] shamt_b,
  input  logic       dir_a,
  input  logic       dir_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] result,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // owner holds the in-flight requester and doubles as the last-owner bit (1 = B)
  logic        owner;
  logic        grant;
  logic        win_b;

  logic [7:0]  op_data;
  logic [2:0]  op_shamt;
  logic        op_dir;

  logic [15:0] dbl;
  logic [15:0] dbl_l;
  logic [15:0] dbl_r;
  logic [7:0]  rot;

  always_comb begin
    grant = (state == IDLE) && (req_a || req_b);
    win_b = req_b && (!req_a || !owner);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_a || req_b) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Rotating a doubled operand turns both directions into plain shifts.
  always_comb begin
    dbl   = {op_data, op_data};
    dbl_l = dbl << op_shamt;
    dbl_r = dbl >> op_shamt;
    rot   = op_dir ? dbl_r[7:0] : dbl_l[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 1'b1;
      op_data  <= '0;
      op_shamt <= '0;
      op_dir   <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      result   <= '0;
      op_count <= '0;
    end else begin
      gnt_a  <= grant && !win_b;
      gnt_b  <= grant && win_b;
      done_a <= (state == EXEC) && !owner;
      done_b <= (state == EXEC) && owner;
      if (grant) begin
        owner    <= win_b;
        op_data  <= win_b ? data_b  : data_a;
        op_shamt <= win_b ? shamt_b : shamt_a;
        op_dir   <= win_b ? dir_b   : dir_a;
      end
      if (state == EXEC) begin
        result <= rot;
        if (op_count != 8'hFF) op_count <= op_count + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: rotate results, latency, fairness, abort and counter saturation.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic [2:0] shamt_a, shamt_b;
  logic       dir_a, dir_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [7:0] result;
  logic       busy;
  logic [7:0] op_count;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  shift_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .shamt_a  (shamt_a),
    .shamt_b  (shamt_b),
    .dir_a    (dir_a),
    .dir_b    (dir_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .result   (result),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // flags = {gnt_a, gnt_b, done_a, done_b, busy}
  function automatic logic [7:0] flags();
    return {3'b000, gnt_a, gnt_b, done_a, done_b, busy};
  endfunction

  // One isolated operation; operands are scrambled after the grant to show they were captured.
  task automatic do_op(input string tag, input logic use_b, input logic [7:0] d,
                       input logic [2:0] sh, input logic dr,
                       input logic [7:0] exp_res, input logic [7:0] exp_cnt);
    if (use_b) begin
      data_b = d; shamt_b = sh; dir_b = dr; req_b = 1'b1;
    end else begin
      data_a = d; shamt_a = sh; dir_a = dr; req_a = 1'b1;
    end
    tick();
    check({tag, "_gnt"}, flags(), use_b ? 8'h09 : 8'h11);
    req_a = 1'b0; req_b = 1'b0;
    data_a = ~d; data_b = ~d; shamt_a = sh + 3'd1; shamt_b = sh + 3'd1;
    dir_a = ~dr; dir_b = ~dr;
    tick();
    check({tag, "_done"}, flags(), use_b ? 8'h03 : 8'h05);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_count"}, op_count, exp_cnt);
    tick();
    check({tag, "_idle"}, flags(), 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; shamt_a = '0; shamt_b = '0; dir_a = 1'b0; dir_b = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_flags", flags(), 8'h00);
    check("rst_result", result, 8'h00);
    check("rst_count", op_count, 8'h00);
    rst_n = 1'b1;

    // Rotate directions and boundary shift amounts
    do_op("a_rotl1",   1'b0, 8'h81, 3'd1, 1'b0, 8'h03, 8'd1);
    do_op("b_rotr3",   1'b1, 8'h01, 3'd3, 1'b1, 8'h20, 8'd2);
    do_op("b_rotr0",   1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 8'd3);
    do_op("a_sym_l4",  1'b0, 8'hA5, 3'd4, 1'b0, 8'h5A, 8'd4);
    do_op("a_sym_r4",  1'b0, 8'hA5, 3'd4, 1'b1, 8'h5A, 8'd5);
    do_op("a_rotl7",   1'b0, 8'h81, 3'd7, 1'b0, 8'hC0, 8'd6);
    do_op("b_rotr2",   1'b1, 8'h81, 3'd2, 1'b1, 8'h60, 8'd7);
    do_op("b_rotl0",   1'b1, 8'h3C, 3'd0, 1'b0, 8'h3C, 8'd8);
    repeat (3) tick();
    check("result_hold", result, 8'h3C);

    // Fairness: both requests held high from reset, A wins the first tie
    apply_reset();
    data_a = 8'h12; shamt_a = 3'd1; dir_a = 1'b0;
    data_b = 8'h12; shamt_b = 3'd1; dir_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic is_b;
      is_b = (i % 2) == 1;
      tick();
      check("fair_gnt", flags(), is_b ? 8'h09 : 8'h11);
      tick();
      check("fair_done", flags(), is_b ? 8'h03 : 8'h05);
      check("fair_result", result, is_b ? 8'h09 : 8'h24);
      tick();
      check("fair_idle", flags(), 8'h00);
      if (i == 5) begin
        req_a = 1'b0; req_b = 1'b0;
      end
    end
    check("fair_count", op_count, 8'd6);

    // Abort: reset during EXEC suppresses done and the count
    data_a = 8'h81; shamt_a = 3'd1; dir_a = 1'b0;
    req_a = 1'b1;
    tick();
    check("abort_gnt", flags(), 8'h11);
    req_a = 1'b0;
    rst_n = 1'b0;
    #2;
    check("abort_flags_async", flags(), 8'h00);
    check("abort_result", result, 8'h00);
    check("abort_count", op_count, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_no_done", flags(), 8'h00);
    do_op("abort_after", 1'b0, 8'h81, 3'd1, 1'b0, 8'h03, 8'd1);

    // Saturation: 257 back-to-back A operations
    apply_reset();
    data_a = 8'h01; shamt_a = 3'd1; dir_a = 1'b0;
    req_a = 1'b1;
    repeat (3 * 254) tick();
    check("sat_254", op_count, 8'hFE);
    repeat (3) tick();
    check("sat_255", op_count, 8'hFF);
    repeat (3) tick();
    check("sat_256", op_count, 8'hFF);
    tick();
    check("sat_gnt_257", flags(), 8'h11);
    tick();
    check("sat_done_257", flags(), 8'h05);
    check("sat_result", result, 8'h02);
    check("sat_257", op_count, 8'hFF);
    req_a = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
